// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared constants and FSM state type for the MEM stage.
// No ports; imported by data_memory and mem_access_stage.
package mem_stage_pkg;

    localparam int WORD_W        = 32;
    localparam int DEF_BASE_ADDR = 1024;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        BUSY = ST_BUSY,
        DONE = ST_DONE
    } state_t;

endpackage

// File: rtl/data_memory.sv
// data_memory: word-addressed RAM, synchronous write, registered read.
// Ports: clk, we, re, addr (word index), wdata, rdata (updated only when re).
module data_memory
    import mem_stage_pkg::*;
#(
    parameter int DEPTH = 64
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic                     re,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [WORD_W-1:0]        wdata,
    output logic [WORD_W-1:0]        rdata
);

    logic [WORD_W-1:0] mem [DEPTH];

    // Read sees the pre-write word when we and re hit the same edge.
    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
        if (re) rdata <= mem[addr];
    end

endmodule

// File: rtl/mem_access_stage.sv
// mem_access_stage: MEM pipeline stage, LDR/STR with fixed latency + freeze.
// Ports: clk, rst (async low), EXE inputs (wbEnIn, memREnIn, memWEnIn,
// aluResIn, valRmIn, destIn), passthrough outputs (wbEnOut, memREnOut,
// aluResOut, destOut), memDataOut (load data), freeze (pipeline stall).
// Optional MEM_ADDR_CHECK_EN: adds addrErr, blocks out-of-range accesses;
// otherwise the word index wraps modulo DEPTH (DEPTH a power of two).
module mem_access_stage
    import mem_stage_pkg::*;
#(
    parameter int DEPTH       = 64,
    parameter int BASE_ADDR   = DEF_BASE_ADDR,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wbEnIn,
    input  logic              memREnIn,
    input  logic              memWEnIn,
    input  logic [WORD_W-1:0] aluResIn,
    input  logic [WORD_W-1:0] valRmIn,
    input  logic [3:0]        destIn,
    output logic              wbEnOut,
    output logic              memREnOut,
    output logic [WORD_W-1:0] aluResOut,
    output logic [3:0]        destOut,
    output logic [WORD_W-1:0] memDataOut,
`ifdef MEM_ADDR_CHECK_EN
    output logic              addrErr,
`endif
    output logic              freeze
);

    localparam int                AW      = $clog2(DEPTH);
    localparam logic [3:0]        WAIT_LD = 4'(WAIT_CYCLES);
    localparam logic [WORD_W-1:0] BASE    = WORD_W'(BASE_ADDR);

    state_t            state;
    state_t            state_nx;
    logic [3:0]        cnt;
    logic [3:0]        cnt_nx;
    logic              req;
    logic              commit;
    logic              in_range;
    logic [AW-1:0]     addr;
    logic              mem_we;
    logic              mem_re;
    logic              rd_ok;
    logic [WORD_W-1:0] rdata;

    assign wbEnOut   = wbEnIn;
    assign memREnOut = memREnIn;
    assign aluResOut = aluResIn;
    assign destOut   = destIn;

    assign req  = memREnIn | memWEnIn;
    assign addr = AW'((aluResIn - BASE) >> 2);

`ifdef MEM_ADDR_CHECK_EN
    assign in_range = (aluResIn >= BASE) &&
                      (((aluResIn - BASE) >> 2) < WORD_W'(DEPTH));
`else
    assign in_range = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        commit   = 1'b0;
        unique case (state)
            IDLE: begin
                if (req) begin
                    if (WAIT_CYCLES == 0) begin
                        commit   = 1'b1;
                        state_nx = DONE;
                    end else begin
                        cnt_nx   = WAIT_LD;
                        state_nx = BUSY;
                    end
                end
            end
            BUSY: begin
                cnt_nx = cnt - 4'd1;
                if (cnt == 4'd1) begin
                    commit   = 1'b1;
                    state_nx = DONE;
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // DONE is the release cycle: the pipeline advances on its closing edge.
    assign freeze = req && (state != DONE);

    assign mem_we = commit && memWEnIn && in_range;
    assign mem_re = commit && memREnIn;

    data_memory #(
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .re    (mem_re),
        .addr  (addr),
        .wdata (valRmIn),
        .rdata (rdata)
    );

    // The RAM read register has no reset; rd_ok zeroes the output after
    // reset and after an out-of-range load.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rd_ok <= 1'b0;
        else if (mem_re) rd_ok <= in_range;
    end

    assign memDataOut = rd_ok ? rdata : '0;

`ifdef MEM_ADDR_CHECK_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) addrErr <= 1'b0;
        else if (commit) addrErr <= !in_range;
    end
`endif

endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: self-checking bench, two DUTs (WAIT_CYCLES 2 and 0).
// Directed table, reset/back-to-back sequences, random ops vs a model.
module tb_mem_access_stage;
    import mem_stage_pkg::*;

    localparam int DEPTH = 64;
    localparam int WC [2] = '{2, 0};

    logic        clk = 1'b0;
    logic        rst;
    logic        wb [2];
    logic        rE [2];
    logic        wE [2];
    logic [31:0] alu [2];
    logic [31:0] rm [2];
    logic [3:0]  dst [2];
    logic        wbo [2];
    logic        rEo [2];
    logic [31:0] aluo [2];
    logic [3:0]  dsto [2];
    logic [31:0] md [2];
    logic        frz [2];
`ifdef MEM_ADDR_CHECK_EN
    logic        aerr [2];
`endif

    always #5 clk = ~clk;

    mem_access_stage #(.DEPTH(DEPTH), .BASE_ADDR(1024), .WAIT_CYCLES(2)) u0 (
        .clk(clk), .rst(rst), .wbEnIn(wb[0]), .memREnIn(rE[0]),
        .memWEnIn(wE[0]), .aluResIn(alu[0]), .valRmIn(rm[0]),
        .destIn(dst[0]), .wbEnOut(wbo[0]), .memREnOut(rEo[0]),
        .aluResOut(aluo[0]), .destOut(dsto[0]), .memDataOut(md[0]),
`ifdef MEM_ADDR_CHECK_EN
        .addrErr(aerr[0]),
`endif
        .freeze(frz[0])
    );

    mem_access_stage #(.DEPTH(DEPTH), .BASE_ADDR(1024), .WAIT_CYCLES(0)) u1 (
        .clk(clk), .rst(rst), .wbEnIn(wb[1]), .memREnIn(rE[1]),
        .memWEnIn(wE[1]), .aluResIn(alu[1]), .valRmIn(rm[1]),
        .destIn(dst[1]), .wbEnOut(wbo[1]), .memREnOut(rEo[1]),
        .aluResOut(aluo[1]), .destOut(dsto[1]), .memDataOut(md[1]),
`ifdef MEM_ADDR_CHECK_EN
        .addrErr(aerr[1]),
`endif
        .freeze(frz[1])
    );

    logic [31:0] mdl [2][DEPTH];
    logic [31:0] mdl_rd [2];
    bit          mdl_err [2];
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Byte address to word: signed offset, floor-divide by 4, mod DEPTH.
    function automatic bit map(input logic [31:0] a, output int w);
        longint off, wi;
        off = longint'({32'd0, a}) - longint'(DEF_BASE_ADDR);
        wi  = off >>> 2;
        w   = int'(((wi % DEPTH) + DEPTH) % DEPTH);
        return (off >= 0) && (wi < DEPTH);
    endfunction

    // Called at posedge+1; returns at the posedge+1 after the op retires.
    task automatic access(input int d, input bit rd, input bit wr,
                          input bit wbe, input logic [31:0] a,
                          input logic [31:0] v, input logic [3:0] ds,
                          output logic [31:0] got);
        int w, n;
        bit ok, okw, req;
        req = rd | wr;
        ok  = map(a, w);
`ifdef MEM_ADDR_CHECK_EN
        okw = ok;
`else
        okw = 1'b1;
`endif
        wb[d] = wbe; rE[d] = rd; wE[d] = wr;
        alu[d] = a; rm[d] = v; dst[d] = ds;
        if (rd) mdl_rd[d] = okw ? mdl[d][w] : 32'd0;
        if (wr && okw) mdl[d][w] = v;
        if (req) mdl_err[d] = !okw;
        #1;
        chk($sformatf("pass d%0d", d),
            {25'd0, wbo[d], rEo[d], dsto[d], aluo[d]},
            {25'd0, wbe, rd, ds, a});
        n = 0;
        @(negedge clk);
        while (frz[d] === 1'b1 && n < 20) begin
            n++;
            @(negedge clk);
        end
        chk($sformatf("latency d%0d a=%h", d, a), 64'(n),
            req ? 64'(WC[d] + 1) : 64'd0);
        chk($sformatf("memData d%0d a=%h", d, a), {32'd0, md[d]},
            {32'd0, mdl_rd[d]});
`ifdef MEM_ADDR_CHECK_EN
        chk($sformatf("addrErr d%0d a=%h", d, a), {63'd0, aerr[d]},
            {63'd0, mdl_err[d]});
`endif
        got = md[d];
        @(posedge clk);
        #1;
        wb[d] = 1'b0; rE[d] = 1'b0; wE[d] = 1'b0;
    endtask

    typedef struct {
        bit          rd;
        bit          wr;
        bit          wbe;
        logic [31:0] a;
        logic [31:0] v;
        logic [3:0]  ds;
        bit          cd;
        logic [31:0] ed;
        bit          ee;
    } vec_t;

    vec_t tbl [9];
    bit   chkmode;

    initial begin
        logic [31:0] got;
`ifdef MEM_ADDR_CHECK_EN
        chkmode = 1'b1;
`else
        chkmode = 1'b0;
`endif
        for (int d = 0; d < 2; d++) begin
            wb[d] = 0; rE[d] = 0; wE[d] = 0;
            alu[d] = 0; rm[d] = 0; dst[d] = 0;
            mdl_rd[d] = 0; mdl_err[d] = 0;
        end

        tbl[0] = '{1'b0, 1'b1, 1'b0, 32'd1024, 32'h11111111, 4'd0,
                   1'b0, 32'd0, 1'b0};
        tbl[1] = '{1'b0, 1'b1, 1'b0, 32'd1028, 32'hDEADBEEF, 4'd0,
                   1'b0, 32'd0, 1'b0};
        tbl[2] = '{1'b1, 1'b0, 1'b1, 32'd1028, 32'd0, 4'd5,
                   1'b1, 32'hDEADBEEF, 1'b0};
        tbl[3] = '{1'b1, 1'b0, 1'b1, 32'd1029, 32'd0, 4'd6,
                   1'b1, 32'hDEADBEEF, 1'b0};
        tbl[4] = '{1'b0, 1'b1, 1'b0, 32'd1280, 32'h22222222, 4'd0,
                   1'b1, 32'hDEADBEEF, chkmode};
        tbl[5] = '{1'b1, 1'b0, 1'b1, 32'd1024, 32'd0, 4'd7,
                   1'b1, chkmode ? 32'h11111111 : 32'h22222222, 1'b0};
        tbl[6] = '{1'b0, 1'b1, 1'b0, 32'd1156, 32'h33333333, 4'd0,
                   1'b1, chkmode ? 32'h11111111 : 32'h22222222, 1'b0};
        tbl[7] = '{1'b1, 1'b0, 1'b1, 32'd900, 32'd0, 4'd8,
                   1'b1, chkmode ? 32'h0 : 32'h33333333, chkmode};
        tbl[8] = '{1'b0, 1'b0, 1'b1, 32'h55, 32'd0, 4'd3,
                   1'b1, chkmode ? 32'h0 : 32'h33333333, chkmode};

        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("reset freeze d%0d", d), {63'd0, frz[d]}, 64'd0);
            chk($sformatf("reset memData d%0d", d), {32'd0, md[d]}, 64'd0);
`ifdef MEM_ADDR_CHECK_EN
            chk($sformatf("reset addrErr d%0d", d), {63'd0, aerr[d]}, 64'd0);
`endif
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        for (int d = 0; d < 2; d++)
            for (int w = 0; w < DEPTH; w++)
                access(d, 1'b0, 1'b1, 1'b0, 32'(1024 + 4 * w), $urandom,
                       4'd0, got);

        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 9; i++) begin
                access(d, tbl[i].rd, tbl[i].wr, tbl[i].wbe, tbl[i].a,
                       tbl[i].v, tbl[i].ds, got);
                if (tbl[i].cd)
                    chk($sformatf("table d%0d row%0d", d, i), {32'd0, got},
                        {32'd0, tbl[i].ed});
`ifdef MEM_ADDR_CHECK_EN
                chk($sformatf("table err d%0d row%0d", d, i),
                    {63'd0, aerr[d]}, {63'd0, tbl[i].ee});
`endif
            end

        access(0, 1'b0, 1'b1, 1'b0, 32'd1032, 32'hAAAA5555, 4'd0, got);
        wE[0] = 1'b1; alu[0] = 32'd1032; rm[0] = 32'h1234;
        @(negedge clk);
        chk("rst-mid freeze before", {63'd0, frz[0]}, 64'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        wE[0] = 1'b0;
        #1;
        chk("rst-mid freeze", {63'd0, frz[0]}, 64'd0);
        chk("rst-mid memData d0", {32'd0, md[0]}, 64'd0);
        chk("rst-mid memData d1", {32'd0, md[1]}, 64'd0);
        @(negedge clk);
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            mdl_rd[d] = 0;
            mdl_err[d] = 0;
        end
        @(posedge clk);
        #1;
        access(0, 1'b1, 1'b0, 1'b1, 32'd1032, 32'd0, 4'd1, got);
        chk("rst-mid store dropped", {32'd0, got}, {32'd0, 32'hAAAA5555});

        access(1, 1'b1, 1'b0, 1'b1, 32'd1024, 32'd0, 4'd2, got);
        access(1, 1'b1, 1'b0, 1'b1, 32'd1028, 32'd0, 4'd4, got);
        access(1, 1'b1, 1'b1, 1'b1, 32'd1036, 32'h0BADF00D, 4'd9, got);
        access(1, 1'b1, 1'b0, 1'b1, 32'd1036, 32'd0, 4'd9, got);
        chk("rmw store landed", {32'd0, got}, {32'd0, 32'h0BADF00D});

        for (int i = 0; i < 300; i++) begin
            int d, k;
            logic [31:0] a;
            d = int'($urandom_range(1, 0));
            k = int'($urandom_range(3, 0));
            if ($urandom_range(7, 0) == 0) a = 32'($urandom_range(1400, 800));
            else a = 32'(1024 + $urandom_range(DEPTH * 4 - 1, 0));
            access(d, k[0], k[1], k[0] | (k == 0), a, $urandom,
                   4'($urandom_range(15, 0)), got);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- MEM stage of the 5-stage ARM-subset pipeline, directly downstream of the EXE stage.
- Consumes the EXE-stage ALU result (used as the address), the forwarded Rm value (store data), the destination register and the control bits.
- Performs LDR/STR against a local word-addressed data memory with a fixed, configurable access latency.
- Raises `freeze` to stall the whole pipeline until the access completes, then passes results to WB.

Parameters:
- `DEPTH`, 64: number of 32-bit words in the data memory.
- `BASE_ADDR`, 1024: byte address mapped to word 0.
- `WAIT_CYCLES`, 2: extra stall cycles per memory access (0 allowed).

Ports:
- `clk`  in  1  pipeline clock, rising edge
- `rst`  in  1  asynchronous, active-low reset
- `wbEnIn`  in  1  write-back enable from EXE
- `memREnIn`  in  1  load request
- `memWEnIn`  in  1  store request
- `aluResIn`  in  32  byte address (mem ops) or ALU result
- `valRmIn`  in  32  store data
- `destIn`  in  4  destination register
- `wbEnOut`  out  1  = `wbEnIn`
- `memREnOut`  out  1  = `memREnIn` (WB mux select)
- `aluResOut`  out  32  = `aluResIn`
- `destOut`  out  4  = `destIn`
- `memDataOut`  out  32  registered load data
- `freeze`  out  1  stall request to all upstream pipeline registers and PC

Behaviour:
- **Passthrough:** `wbEnOut`, `memREnOut`, `aluResOut` and `destOut` are combinational copies of their inputs.
- **Request:** `req` = `memREnIn` | `memWEnIn`.
- **Address:** word index = (`aluResIn` - `BASE_ADDR`) >> 2; bits [1:0] ignored (no misalignment trap).
- **FSM states:** IDLE, BUSY, DONE. 4-bit down-counter `cnt`.
- **IDLE:**
  - `req`=0: stay in IDLE.
  - `req`=1 and `WAIT_CYCLES`=0: commit the access and go to DONE.
  - `req`=1 and `WAIT_CYCLES`>0: load `cnt`=`WAIT_CYCLES` and go to BUSY.
- **BUSY:** decrement `cnt` each cycle. On the edge where `cnt`==1, commit the access and go to DONE.
- **DONE:** go to IDLE unconditionally. The pipeline advances at this edge; because the state is IDLE only after the instruction has left, the same instruction never re-triggers.
- **freeze:** `req` && state != DONE, combinational.
- **Latency:** a request present in cycle 0 sees `freeze`=1 for cycles 0..`WAIT_CYCLES` and `freeze`=0 in cycle `WAIT_CYCLES`+1. Total occupancy is `WAIT_CYCLES`+2 cycles.
- **Commit:**
  - Store writes `valRmIn` to mem[index].
  - Load registers mem[index] into `memDataOut`.
  - `memDataOut` holds its value until the next load commit.
- **Simultaneous read and write:** write takes priority; `memDataOut` captures the pre-write value.
- **Address out of range** (index >= `DEPTH` or `aluResIn` < `BASE_ADDR`): behaviour is governed by the optional feature below. The access still takes full latency.
- **Reset** (`rst`=0, asynchronous):
  - State goes to IDLE, `cnt`=0, `memDataOut`=0.
  - A pending store that has not yet committed is dropped.
  - Memory contents are not reset.
- **Idle stability:** inputs change only when `freeze`=0, because upstream registers hold during a stall. The block needs no input capture.

Optional Feature:
- **Macro:** `MEM_ADDR_CHECK_EN`.
- **Defined:**
  - Adds output port `addrErr` (1 bit). It is registered, set at the commit edge of an out-of-range access and cleared at the next commit edge or on reset.
  - Out-of-range stores are suppressed.
  - Out-of-range loads return 0.
- **Undefined:** no `addrErr` port; the index wraps modulo `DEPTH` (low log2(`DEPTH`) bits used).

Decomposition:
- **Shared package `mem_stage_pkg`:**
  - FSM state encoding constants: IDLE=2'd0, BUSY=2'd1, DONE=2'd2.
  - Default `BASE_ADDR` constant.
  - Word-width constant (32).
- **Sub-module `data_memory`:**
  - Parameter `DEPTH`.
  - Ports: `clk`, `we`, `re`, `addr`, `wdata`, `rdata`.
  - Synchronous write, registered read, no reset on the array.
- The FSM, counter and address translation stay in `mem_access_stage`.

Test Plan:
- **Store then load, default latency (`WAIT_CYCLES`=2):**
  - STR with `aluResIn`=1028, `valRmIn`=0xDEADBEEF: `freeze`=1 for exactly 3 cycles, 0 on the 4th.
  - Later LDR with `aluResIn`=1028: `memDataOut`=0xDEADBEEF when `freeze` drops.
- **Zero-latency build (`WAIT_CYCLES`=0):**
  - LDR: `freeze`=1 for 1 cycle, then 0.
  - Back-to-back LDR/LDR to words 0 and 1 each stall exactly 1 cycle, with no double-commit.
- **Non-memory instruction:** `wbEnIn`=1, `aluResIn`=0x55, `destIn`=3, no req → `freeze` stays 0; `aluResOut`=0x55, `destOut`=3 same cycle; `memDataOut` unchanged.
- **Reset mid-access:**
  - STR to 1032 with 0x1234; assert `rst`=0 while in BUSY.
  - State goes to IDLE, `freeze`=0, `memDataOut`=0.
  - Subsequent LDR of 1032 returns the previous contents, not 0x1234.
- **Out of range, with `MEM_ADDR_CHECK_EN`:** STR to 1024+4*`DEPTH`: `addrErr`=1 after commit, memory unchanged; LDR of 900 returns 0 with `addrErr`=1.
- **Out of range, without `MEM_ADDR_CHECK_EN`:** the same STR wraps to word 0.
- **Low address bits:** LDR of 1029 returns the same data as 1028.
